dmux16_8_sched: RTL

- Round-robin / directed scheduler that feeds the 16-bit 1-to-8 demux tree.
- Accepts a word stream on a valid/ready handshake, selects a destination lane, and drives the demux select and data from registers.
- Holds each word until the chosen lane accepts it.
- Sits between the upstream word source and the eight lane consumers; the demux itself stays purely combinational.

---
 rtl/dmux16_8_sched_pkg.sv | 9 +
 rtl/dmux16_8_sched_if.sv | 22 ++
 rtl/dmux16_8_sched_rr_pick8.sv | 18 +
 rtl/dmux16_8_sched.sv | 72 +++++++
 4 files changed

// File: rtl/dmux16_8_sched_pkg.sv
// dmux_sched_pkg: shared widths, counter sizes and FSM state type for the demux scheduler
package dmux_sched_pkg;
  localparam int WIDTH  = 16;
  localparam int LANES  = 8;
  localparam int SEL_W  = 3;
  localparam int DISP_W = 16;
  localparam int DROP_W = 8;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/dmux16_8_sched_if.sv
// dmux16_8_sched_if: upstream word handshake plus lane-side demux bus
// master: word source / lane consumers; slave: the scheduler
interface dmux16_8_sched_if;
  import dmux_sched_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dest_en;
  logic [SEL_W-1:0] in_dest;
  logic [LANES-1:0] lane_ready;
  logic [SEL_W-1:0] dmux_sel;
  logic [WIDTH-1:0] dmux_a;
  logic [LANES-1:0] lane_valid;
  modport master (
    output in_valid, in_data, in_dest_en, in_dest, lane_ready,
    input  in_ready, dmux_sel, dmux_a, lane_valid
  );
  modport slave (
    input  in_valid, in_data, in_dest_en, in_dest, lane_ready,
    output in_ready, dmux_sel, dmux_a, lane_valid
  );
endinterface

// File: rtl/dmux16_8_sched_rr_pick8.sv
// rr_pick8: circular priority picker, first set mask bit at or after ptr
// mask: enabled lanes; ptr: scan start; idx: chosen lane; found: any lane enabled
module rr_pick8
  import dmux_sched_pkg::*;
(
  input  logic [LANES-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  // scan from the farthest offset down so the nearest enabled lane wins
  always_comb begin
    idx = ptr;
    for (int i = LANES - 1; i >= 0; i--)
      idx = mask[ptr + SEL_W'(i)] ? ptr + SEL_W'(i) : idx;
  end
  assign found = |mask;
endmodule

// File: rtl/dmux16_8_sched.sv
// dmux16_8_sched: round-robin/directed scheduler driving a 1-to-8 16-bit demux from registers
// clk/rst_n: clock, async active-low reset; cfg_lane_mask: enabled lanes
// bus: upstream valid/ready word stream in, registered demux select/data and one-hot lane_valid out
// disp_cnt: wrapping delivery count; drop_cnt: saturating drop count; drop_pulse: one cycle per drop
module dmux16_8_sched
  import dmux_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  cfg_lane_mask,
  dmux16_8_sched_if.slave   bus,
  output logic [DISP_W-1:0] disp_cnt,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_pulse
);
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [DISP_W-1:0] disp_cnt_q, disp_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              done, accept, drop, load;
  rr_pick8 u_pick (
    .mask  (cfg_lane_mask),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );
  // a held word that completes this edge frees the slot for a new word on the same edge
  assign done         = (state_q == HOLD) & bus.lane_ready[sel_q];
  assign bus.in_ready = (bus.in_dest_en | pick_found) & ((state_q == IDLE) | bus.lane_ready[sel_q]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign drop         = accept & bus.in_dest_en & ~cfg_lane_mask[bus.in_dest];
  assign load         = accept & ~drop;
  always_comb begin
    state_d      = load ? HOLD : (done ? IDLE : state_q);
    sel_d        = load ? (bus.in_dest_en ? bus.in_dest : pick_idx) : sel_q;
    a_d          = load ? bus.in_data : a_q;
    rr_ptr_d     = (load & ~bus.in_dest_en) ? pick_idx + SEL_W'(1) : rr_ptr_q;
    disp_cnt_d   = disp_cnt_q + DISP_W'(done);
    drop_cnt_d   = drop_cnt_q + DROP_W'(drop & ~&drop_cnt_q);
    drop_pulse_d = drop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      a_q          <= '0;
      disp_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      a_q          <= a_d;
      disp_cnt_q   <= disp_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end
  assign bus.dmux_sel   = sel_q;
  assign bus.dmux_a     = a_q;
  assign bus.lane_valid = (state_q == HOLD) ? LANES'(1) << sel_q : '0;
  assign disp_cnt       = disp_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign drop_pulse     = drop_pulse_q;
endmodule
